// File: rtl/otbn_pq_pkg.sv
// Shared types for the PQ twiddle loop sequencer.
// BC_* states exist only when OTBN_PQ_BASECASE_EN is defined.
package otbn_pq_pkg;

    localparam int TwLogNW = 4;

    typedef enum logic [1:0] {
        TwNtt      = 2'd0,
        TwIntt     = 2'd1,
        TwBasecase = 2'd2
    } twseq_mode_e;

    typedef enum logic [3:0] {
        StIdle,
        StInit,
        StBfly,
        StTwUpd,
        StLayerEnd,
        StDone
`ifdef OTBN_PQ_BASECASE_EN
        , StBcB0,
        StBcInv0,
        StBcB1,
        StBcInv1,
        StBcUpd
`endif
    } twseq_state_e;

endpackage

// File: rtl/pq_loop_cnt.sv
// Nested two-level counter: the inner index runs fastest and the outer index
// steps when the inner one wraps at its programmed bound.
module pq_loop_cnt #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         advance_i,
    input  logic [W-1:0] outer_max_i,
    input  logic [W-1:0] inner_max_i,
    output logic [W-1:0] outer_o,
    output logic [W-1:0] inner_o,
    output logic         last_inner_o,
    output logic         last_outer_o
);

    logic [W-1:0] outer_q, outer_d;
    logic [W-1:0] inner_q, inner_d;

    assign last_inner_o = (inner_q == inner_max_i);
    assign last_outer_o = (outer_q == outer_max_i);
    assign outer_o      = outer_q;
    assign inner_o      = inner_q;

    always_comb begin
        outer_d = outer_q;
        inner_d = inner_q;
        if (clear_i) begin
            outer_d = '0;
            inner_d = '0;
        end else if (advance_i) begin
            if (last_inner_o) begin
                inner_d = '0;
                outer_d = last_outer_o ? '0 : outer_q + 1'b1;
            end else begin
                inner_d = inner_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outer_q <= '0;
            inner_q <= '0;
        end else begin
            outer_q <= outer_d;
            inner_q <= inner_d;
        end
    end

endmodule

// File: rtl/pq_twiddle_seq.sv
// Loop sequencer walking every NTT/INTT layer, issuing butterfly pairs and twiddle strobes.
// Define OTBN_PQ_BASECASE_EN to add the single-pass basecase-multiplication mode (mode 2).
module pq_twiddle_seq
    import otbn_pq_pkg::*;
#(
    parameter int LOG_N_MAX = 8,
    parameter int IdxW      = LOG_N_MAX
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [1:0]         mode_i,
    input  logic [TwLogNW-1:0] log_n_i,
    input  logic               bfly_ready_i,
    output logic               bfly_valid_o,
    output logic [IdxW-1:0]    bfly_idx_a_o,
    output logic [IdxW-1:0]    bfly_idx_b_o,
    output logic               set_twiddle_as_psi_o,
    output logic               update_twiddle_o,
    output logic               invert_twiddle_o,
    output logic               update_psi_o,
    output logic               update_omega_o,
    output logic               psi_idx_inc_o,
    output logic               omega_idx_inc_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam logic [TwLogNW-1:0] LogNMaxW = TwLogNW'(LOG_N_MAX);

    twseq_state_e       state_q, state_d;
    twseq_mode_e        mode_q, mode_d;
    logic [TwLogNW-1:0] log_n_q, log_n_d;
    logic [TwLogNW-1:0] s_q, s_d;
    logic               err_q, err_d;

    logic [IdxW-1:0] len, outer_max, inner_max, cnt_outer, cnt_inner, ntt_a;
    logic            cnt_clear, cnt_adv, last_inner, last_outer, start_legal;
`ifdef OTBN_PQ_BASECASE_EN
    logic [IdxW-1:0] bc_base;
`else
    assign invert_twiddle_o = 1'b0;
`endif

    pq_loop_cnt #(.W(IdxW)) u_loop_cnt (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (cnt_clear),
        .advance_i    (cnt_adv),
        .outer_max_i  (outer_max),
        .inner_max_i  (inner_max),
        .outer_o      (cnt_outer),
        .inner_o      (cnt_inner),
        .last_inner_o (last_inner),
        .last_outer_o (last_outer)
    );

    // Outer counter is j (len values), inner is g (2^s groups); basecase reuses outer as p.
    always_comb begin
        len       = IdxW'(1) << (log_n_q - s_q - TwLogNW'(1));
        outer_max = len - IdxW'(1);
        inner_max = (IdxW'(1) << s_q) - IdxW'(1);
`ifdef OTBN_PQ_BASECASE_EN
        if (mode_q == TwBasecase) begin
            outer_max = (IdxW'(1) << (log_n_q - TwLogNW'(2))) - IdxW'(1);
            inner_max = '0;
        end
`endif
    end

    // a = g * 2 * len + j, with 2 * len == N >> s
    assign ntt_a = (cnt_inner << (log_n_q - s_q)) + cnt_outer;
`ifdef OTBN_PQ_BASECASE_EN
    assign bc_base = {cnt_outer[IdxW-3:0], 2'b00};
`endif

    always_comb begin
        start_legal = 1'b0;
        if (log_n_i != '0 && log_n_i <= LogNMaxW) begin
            if (mode_i == TwNtt || mode_i == TwIntt) begin
                start_legal = 1'b1;
            end
`ifdef OTBN_PQ_BASECASE_EN
            if (mode_i == TwBasecase && log_n_i >= TwLogNW'(2)) begin
                start_legal = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        state_d              = state_q;
        mode_d               = mode_q;
        log_n_d              = log_n_q;
        s_d                  = s_q;
        err_d                = 1'b0;
        cnt_clear            = 1'b0;
        cnt_adv              = 1'b0;
        bfly_valid_o         = 1'b0;
        bfly_idx_a_o         = '0;
        bfly_idx_b_o         = '0;
        set_twiddle_as_psi_o = 1'b0;
        update_twiddle_o     = 1'b0;
        update_psi_o         = 1'b0;
        update_omega_o       = 1'b0;
        psi_idx_inc_o        = 1'b0;
        omega_idx_inc_o      = 1'b0;
        busy_o               = 1'b0;
        done_o               = 1'b0;
`ifdef OTBN_PQ_BASECASE_EN
        invert_twiddle_o     = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (start_legal) begin
                        state_d = StInit;
                        mode_d  = twseq_mode_e'(mode_i);
                        log_n_d = log_n_i;
                        s_d     = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StInit: begin
                busy_o               = 1'b1;
                set_twiddle_as_psi_o = 1'b1;
                cnt_clear            = 1'b1;
                state_d              = StBfly;
`ifdef OTBN_PQ_BASECASE_EN
                if (mode_q == TwBasecase) begin
                    state_d = StBcB0;
                end
`endif
            end
            StBfly: begin
                busy_o       = 1'b1;
                bfly_valid_o = 1'b1;
                bfly_idx_a_o = ntt_a;
                bfly_idx_b_o = ntt_a + len;
                if (bfly_ready_i) begin
                    cnt_adv = 1'b1;
                    if (last_inner) begin
                        state_d = last_outer ? StLayerEnd : StTwUpd;
                    end
                end
            end
            StTwUpd: begin
                busy_o           = 1'b1;
                update_twiddle_o = 1'b1;
                state_d          = StBfly;
            end
            StLayerEnd: begin
                busy_o = 1'b1;
                if (mode_q == TwIntt) begin
                    update_psi_o   = 1'b1;
                    update_omega_o = 1'b1;
                end else begin
                    psi_idx_inc_o   = 1'b1;
                    omega_idx_inc_o = 1'b1;
                end
                if (s_q == log_n_q - TwLogNW'(1)) begin
                    state_d = StDone;
                end else begin
                    s_d     = s_q + TwLogNW'(1);
                    state_d = StInit;
                end
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
`ifdef OTBN_PQ_BASECASE_EN
            StBcB0: begin
                busy_o       = 1'b1;
                bfly_valid_o = 1'b1;
                bfly_idx_a_o = bc_base;
                bfly_idx_b_o = bc_base | IdxW'(1);
                if (bfly_ready_i) begin
                    state_d = StBcInv0;
                end
            end
            StBcInv0: begin
                busy_o           = 1'b1;
                invert_twiddle_o = 1'b1;
                state_d          = StBcB1;
            end
            StBcB1: begin
                busy_o       = 1'b1;
                bfly_valid_o = 1'b1;
                bfly_idx_a_o = bc_base | IdxW'(2);
                bfly_idx_b_o = bc_base | IdxW'(3);
                if (bfly_ready_i) begin
                    state_d = StBcInv1;
                end
            end
            StBcInv1: begin
                busy_o           = 1'b1;
                invert_twiddle_o = 1'b1;
                state_d          = last_outer ? StDone : StBcUpd;
            end
            StBcUpd: begin
                busy_o           = 1'b1;
                update_twiddle_o = 1'b1;
                cnt_adv          = 1'b1;
                state_d          = StBcB0;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    assign err_o = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            mode_q  <= TwNtt;
            log_n_q <= '0;
            s_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            log_n_q <= log_n_d;
            s_q     <= s_d;
            err_q   <= err_d;
        end
    end

endmodule
